// File: rtl/approx_adder_error_monitor.sv
// Error monitor for approximate adders: recomputes the exact sum,
// accumulates error statistics over a programmed number of samples.
module approx_adder_error_monitor #(
  parameter int IN_W  = 2,
  parameter int OUT_W = 3,
  parameter int ET    = 1,
  parameter int CNT_W = 16,
  parameter int ACC_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] target,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_a,
  input  logic [IN_W-1:0]  in_b,
  input  logic [OUT_W-1:0] in_approx,
  output logic             viol_pulse,
  output logic             done,
  output logic [CNT_W-1:0] stat_samples,
  output logic [ACC_W-1:0] stat_err_sum,
  output logic [OUT_W-1:0] stat_max_err,
  output logic [CNT_W-1:0] stat_viol
);

  typedef enum logic [1:0] {
    IDLE, RUN, DRAIN, DONE
  } state_t;

  state_t state_q, state_d;

  logic [CNT_W-1:0] acc_cnt_q, acc_cnt_d;
  logic [CNT_W-1:0] tgt_q, tgt_d;
  logic [CNT_W-1:0] acc_inc;

  logic             s1_v_q;
  logic [IN_W-1:0]  a_q, b_q;
  logic [OUT_W-1:0] approx_q;

  logic             s2_v_q;
  logic [OUT_W-1:0] err_q;
  logic             viol_q;

  logic [CNT_W-1:0] samp_q;
  logic [ACC_W-1:0] sum_q;
  logic [OUT_W-1:0] max_q;
  logic [CNT_W-1:0] viol_cnt_q;
  logic             vp_q;

  logic             start_ok;
  logic             accept;
  logic [OUT_W-1:0] exact_w;
  logic [OUT_W-1:0] err_w;
  logic             viol_w;
  logic [ACC_W:0]   sum_w;

  assign in_ready = (state_q == RUN);
  assign accept   = in_valid & in_ready;
  assign start_ok = start & ((state_q == IDLE) | (state_q == DONE));
  assign acc_inc  = acc_cnt_q + CNT_W'(1);

  always_comb begin
    state_d   = state_q;
    acc_cnt_d = acc_cnt_q;
    tgt_d     = tgt_q;
    if (start_ok) begin
      tgt_d     = target;
      acc_cnt_d = '0;
      state_d   = (target == '0) ? DONE : RUN;
    end else begin
      unique case (state_q)
        RUN: begin
          if (accept) begin
            acc_cnt_d = acc_inc;
            if (acc_inc == tgt_q) state_d = DRAIN;
          end
        end
        DRAIN: begin
          if (!s1_v_q && !s2_v_q) state_d = DONE;
        end
        default: ;
      endcase
    end
  end

  // exact sum is IN_W+1 bits wide, i.e. exactly OUT_W
  assign exact_w = {1'b0, a_q} + {1'b0, b_q};
  assign err_w   = (exact_w >= approx_q) ? (exact_w - approx_q)
                                         : (approx_q - exact_w);
  assign viol_w  = 32'(err_w) > 32'(ET);
  assign sum_w   = {1'b0, sum_q}
                 + {{(ACC_W+1-OUT_W){1'b0}}, err_q};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      acc_cnt_q  <= '0;
      tgt_q      <= '0;
      s1_v_q     <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      approx_q   <= '0;
      s2_v_q     <= 1'b0;
      err_q      <= '0;
      viol_q     <= 1'b0;
      samp_q     <= '0;
      sum_q      <= '0;
      max_q      <= '0;
      viol_cnt_q <= '0;
      vp_q       <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_cnt_q <= acc_cnt_d;
      tgt_q     <= tgt_d;
      s1_v_q    <= accept;
      if (accept) begin
        a_q      <= in_a;
        b_q      <= in_b;
        approx_q <= in_approx;
      end
      s2_v_q <= s1_v_q;
      if (s1_v_q) begin
        err_q  <= err_w;
        viol_q <= viol_w;
      end
      vp_q <= s2_v_q & viol_q;
      if (start_ok) begin
        samp_q     <= '0;
        sum_q      <= '0;
        max_q      <= '0;
        viol_cnt_q <= '0;
        vp_q       <= 1'b0;
      end else if (s2_v_q) begin
        samp_q <= samp_q + CNT_W'(1);
        sum_q  <= sum_w[ACC_W] ? '1 : sum_w[ACC_W-1:0];
        if (err_q > max_q) max_q <= err_q;
        if (viol_q && viol_cnt_q != '1)
          viol_cnt_q <= viol_cnt_q + CNT_W'(1);
      end
    end
  end

  assign done         = (state_q == DONE);
  assign viol_pulse   = vp_q;
  assign stat_samples = samp_q;
  assign stat_err_sum = sum_q;
  assign stat_max_err = max_q;
  assign stat_viol    = viol_cnt_q;

endmodule

// File: tb/tb_approx_adder_error_monitor.sv
// Directed bench for approx_adder_error_monitor, including a
// narrow-accumulator instance for saturation and a high-ET check.
module tb_approx_adder_error_monitor;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] target;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_a, in_b;
  logic [2:0]  in_approx;
  logic        viol_pulse, done;
  logic [15:0] stat_samples, stat_viol;
  logic [23:0] stat_err_sum;
  logic [2:0]  stat_max_err;

  logic        start2;
  logic [15:0] target2;
  logic        in_valid2, in_ready2;
  logic [1:0]  in_a2, in_b2;
  logic [2:0]  in_approx2;
  logic        viol_pulse2, done2;
  logic [15:0] samples2, viol2;
  logic [2:0]  sum2;
  logic [2:0]  max2;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  approx_adder_error_monitor u_dut (
    .clk(clk), .rst(rst), .start(start), .target(target),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_approx(in_approx),
    .viol_pulse(viol_pulse), .done(done),
    .stat_samples(stat_samples), .stat_err_sum(stat_err_sum),
    .stat_max_err(stat_max_err), .stat_viol(stat_viol)
  );

  approx_adder_error_monitor #(.ET(7), .ACC_W(3)) u_sat (
    .clk(clk), .rst(rst), .start(start2), .target(target2),
    .in_valid(in_valid2), .in_ready(in_ready2),
    .in_a(in_a2), .in_b(in_b2), .in_approx(in_approx2),
    .viol_pulse(viol_pulse2), .done(done2),
    .stat_samples(samples2), .stat_err_sum(sum2),
    .stat_max_err(max2), .stat_viol(viol2)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic stats(input string tag, input int s,
                       input int e, input int m, input int v);
    chk({tag, ".samples"}, 32'(stat_samples), s);
    chk({tag, ".err_sum"}, 32'(stat_err_sum), e);
    chk({tag, ".max_err"}, 32'(stat_max_err), m);
    chk({tag, ".viol"},    32'(stat_viol), v);
  endtask

  task automatic feed(input logic [1:0] a, input logic [1:0] b,
                      input logic [2:0] x);
    in_valid = 1'b1; in_a = a; in_b = b; in_approx = x;
  endtask

  task automatic do_start(input int t);
    start = 1'b1; target = 16'(t);
    step();
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; target = '0;
    in_valid = 1'b0; in_a = '0; in_b = '0; in_approx = '0;
    start2 = 1'b0; target2 = '0;
    in_valid2 = 1'b0; in_a2 = '0; in_b2 = '0; in_approx2 = '0;
    step(); step();
    rst = 1'b0;
    chk("rst.in_ready", 32'(in_ready), 0);
    chk("rst.done", 32'(done), 0);
    chk("rst.vp", 32'(viol_pulse), 0);
    stats("rst", 0, 0, 0, 0);

    // exact approximations, back-to-back
    do_start(4);
    chk("t1.in_ready", 32'(in_ready), 1);
    feed(3, 2, 5); step(); chk("t1.vp1", 32'(viol_pulse), 0);
    feed(1, 1, 2); step(); chk("t1.vp2", 32'(viol_pulse), 0);
    feed(0, 3, 3); step(); chk("t1.vp3", 32'(viol_pulse), 0);
    feed(2, 2, 4); step(); chk("t1.vp4", 32'(viol_pulse), 0);
    in_valid = 1'b0;
    chk("t1.ready_drop", 32'(in_ready), 0);
    step(); chk("t1.vp5", 32'(viol_pulse), 0);
    step(); chk("t1.vp6", 32'(viol_pulse), 0);
    chk("t1.done_early", 32'(done), 0);
    step();
    chk("t1.done", 32'(done), 1);
    stats("t1", 4, 0, 0, 0);

    // errors 4,1,2 with ET=1
    do_start(3);
    stats("t2.clear", 0, 0, 0, 0);
    feed(3, 3, 2); step(); chk("t2.vp_a", 32'(viol_pulse), 0);
    feed(1, 0, 2); step(); chk("t2.vp_b", 32'(viol_pulse), 0);
    feed(2, 1, 1); step(); chk("t2.vp_c", 32'(viol_pulse), 1);
    in_valid = 1'b0;
    step(); chk("t2.vp_d", 32'(viol_pulse), 0);
    step(); chk("t2.vp_e", 32'(viol_pulse), 1);
    chk("t2.done_early", 32'(done), 0);
    step(); chk("t2.vp_f", 32'(viol_pulse), 0);
    chk("t2.done", 32'(done), 1);
    stats("t2", 3, 7, 4, 2);

    // bubbles, then valid held past target
    do_start(2);
    feed(1, 2, 3); step();
    in_valid = 1'b0; step(); step();
    chk("t3.samples_mid", 32'(stat_samples), 1);
    feed(3, 1, 0); step();
    chk("t3.ready_drop", 32'(in_ready), 0);
    step();
    chk("t3.ready_held", 32'(in_ready), 0);
    step();
    chk("t3.vp", 32'(viol_pulse), 1);
    step();
    in_valid = 1'b0;
    chk("t3.done", 32'(done), 1);
    stats("t3", 2, 4, 4, 1);

    // target=0 from IDLE
    rst = 1'b1; step(); rst = 1'b0;
    do_start(0);
    chk("t4.done", 32'(done), 1);
    chk("t4.in_ready", 32'(in_ready), 0);
    stats("t4", 0, 0, 0, 0);
    step();
    chk("t4.in_ready2", 32'(in_ready), 0);

    // reset mid-run discards in-flight samples
    do_start(5);
    feed(3, 3, 2); step(); step();
    in_valid = 1'b0;
    rst = 1'b1; step(); rst = 1'b0;
    chk("t5.in_ready", 32'(in_ready), 0);
    chk("t5.done", 32'(done), 0);
    chk("t5.vp", 32'(viol_pulse), 0);
    stats("t5.rst", 0, 0, 0, 0);
    step(); step();
    chk("t5.flushed", 32'(stat_samples), 0);
    chk("t5.vp_flushed", 32'(viol_pulse), 0);
    do_start(1);
    feed(3, 3, 6); step();
    in_valid = 1'b0;
    step(); step();
    chk("t5.done_early", 32'(done), 0);
    step();
    chk("t5.done1", 32'(done), 1);
    stats("t5", 1, 0, 0, 0);

    // start during RUN is ignored
    do_start(2);
    feed(3, 3, 2); step();
    in_valid = 1'b0;
    start = 1'b1; target = 16'd1; step();
    start = 1'b0;
    step();
    chk("t6.samples", 32'(stat_samples), 1);
    chk("t6.in_ready", 32'(in_ready), 1);
    feed(0, 0, 0); step();
    in_valid = 1'b0;
    step(); step(); step();
    chk("t6.done", 32'(done), 1);
    stats("t6", 2, 4, 4, 1);

    // saturation of a 3-bit sum, ET above max error
    start2 = 1'b1; target2 = 16'd3; step(); start2 = 1'b0;
    in_valid2 = 1'b1; in_a2 = 2'd3; in_b2 = 2'd3; in_approx2 = 3'd2;
    step(); step(); step();
    in_valid2 = 1'b0;
    step(); step(); step();
    chk("t7.done", 32'(done2), 1);
    chk("t7.samples", 32'(samples2), 3);
    chk("t7.err_sum", 32'(sum2), 7);
    chk("t7.max_err", 32'(max2), 4);
    chk("t7.viol", 32'(viol2), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/approx_adder_error_monitor.md
Name: approx_adder_error_monitor

Overview:
- Downstream checking stage for the generated approximate adder netlists (2-bit + 2-bit operands, 3-bit result, per-design error threshold).
- Consumes operand pairs plus the approximate circuit's output over a valid/ready stream and recomputes the exact sum.
- Accumulates error statistics for a programmed number of samples: count, error sum, max error and threshold violations.
- Reports completion so the synthesis flow can accept or reject a candidate against ET.

Parameters:
- IN_W, 2, operand width. OUT_W must equal IN_W+1.
- OUT_W, 3, approximate/exact result width.
- ET, 1, error threshold. A sample violates when abs error > ET (strict).
- CNT_W, 16, width of the sample target and of the sample/violation counters.
- ACC_W, 24, width of the error-sum accumulator.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; loads target, clears stats. Honoured only in IDLE or DONE.
- target  in  CNT_W  number of samples to accept, sampled on start.
- in_valid  in  1  upstream sample valid.
- in_ready  out  1  monitor accepts a sample.
- in_a  in  IN_W  operand a.
- in_b  in  IN_W  operand b.
- in_approx  in  OUT_W  approximate adder output for (in_a, in_b).
- viol_pulse  out  1  one-cycle pulse per violating sample.
- done  out  1  run complete, stats final.
- stat_samples  out  CNT_W  samples fully processed.
- stat_err_sum  out  ACC_W  sum of abs errors, saturating.
- stat_max_err  out  OUT_W  maximum abs error seen.
- stat_viol  out  CNT_W  violating samples, saturating.

Behaviour:
- Reset (rst=1 at a clk edge), required output values:
  - state=IDLE, in_ready=0, done=0, viol_pulse=0.
  - all stat_* = 0.
  - pipeline valid bits = 0.
  - rst has priority over every other input.
- FSM states are IDLE, RUN, DRAIN and DONE:
  - IDLE → RUN on start when target≠0. IDLE → DONE on start when target=0; all stats stay 0.
  - RUN: in_ready=1. A sample is accepted when in_valid&in_ready. On the cycle the accepted count reaches target, next state is DRAIN and in_ready drops on the next cycle.
  - DRAIN: in_ready=0. Wait until both pipeline stages are empty, then → DONE.
  - DONE: done=1, stats frozen. start → RUN (or DONE again if target=0) with stats cleared in the same edge.
  - start in RUN or DRAIN is ignored.
- Accept counter: a separate CNT_W counter of accepted samples, distinct from stat_samples. Cleared on start.
- Pipeline stage S1 (edge of acceptance): register a, b, approx. Compute exact = a+b, zero-extended to OUT_W.
- Pipeline stage S2 (next edge):
  - err = |exact − approx|, unsigned, OUT_W bits.
  - viol = err > ET.
  - Register err and viol.
- Stats update (third edge after acceptance):
  - stat_samples += 1.
  - stat_err_sum += err, saturating at 2^ACC_W−1.
  - stat_max_err = max(stat_max_err, err).
  - stat_viol += viol, saturating at 2^CNT_W−1.
  - viol_pulse=1 for exactly that cycle when viol.
- Latency and throughput:
  - A sample accepted at edge t is reflected in stats after edge t+2.
  - done rises no earlier than the edge after the last stats update.
  - Throughput is 1 sample/cycle. Back-to-back accepts are supported with no bubbles.
  - in_valid low inserts bubbles; bubbles do not update stats.
- Boundaries:
  - target=1: exactly one accept; done asserted 3 cycles after the accept edge.
  - in_valid held high past target: extra samples are not accepted (in_ready=0).
  - rst during RUN or DRAIN: in-flight samples are discarded and everything returns to reset values.
  - ET ≥ 2^OUT_W−1: stat_viol stays 0.

Test Plan:
- Reset, then start target=4. Feed (a,b,approx)=(3,2,5),(1,1,2),(0,3,3),(2,2,4) back-to-back → stat_samples=4, err_sum=0, max_err=0, viol=0, no viol_pulse; done high 3 cycles after the 4th accept.
- start target=3 with ET=1. Feed (3,3,2),(1,0,2),(2,1,1) → errors 4,1,2; err_sum=7, max_err=4, viol=2; viol_pulse exactly on the 1st and 3rd update cycles.
- start target=2, in_valid toggled 1,0,0,1 → only 2 accepts; stats updated only for those; in_ready low after the 2nd accept while in_valid stays high.
- start target=0 from IDLE → done=1 on the next cycle, all stats 0, in_ready never 1.
- Mid-run: 2 of 5 samples accepted, pulse rst → all outputs at reset values next cycle. New start target=1 with sample (3,3,6) → done, samples=1, err_sum=0.
- start pulsed during RUN → ignored (target unchanged, stats retained). Saturation check with ACC_W=3, 3 samples of err 4 → err_sum=7.
